// File: rtl/tilt_pkg.sv
// Shared types, default constants and helpers for the tilt conditioning path.
package tilt_pkg;

    typedef enum logic [1:0] {
        StCenter = 2'd0,
        StLeft   = 2'd1,
        StRight  = 2'd2
    } tilt_state_e;

    localparam int unsigned DefSampleDiv = 100000;
    localparam int unsigned DefAvgLog2   = 2;
    localparam int unsigned DefEnterTh   = 3;
    localparam int unsigned DefExitTh    = 1;

    // |v| for a 5-bit signed value; -16 has no 4-bit magnitude and clamps to 15.
    function automatic logic [3:0] sat_abs5(input logic signed [4:0] v);
        logic [4:0] neg;
        neg = -v;
        if (v[4] && (v[3:0] == 4'd0)) begin
            return 4'd15;
        end else if (v[4]) begin
            return neg[3:0];
        end else begin
            return v[3:0];
        end
    endfunction

endpackage

// File: rtl/acl_sample_sync.sv
// Brings the lateral-axis field into the clk domain and issues one accept per sample tick,
// deferred until the synchronised value is stable.
module acl_sample_sync
    import tilt_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = DefSampleDiv
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] raw,
    output logic       accept,
    output logic [4:0] sample
);

    localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [CntW-1:0] cnt_q;
    logic [4:0]      s1_q;
    logic [4:0]      s2_q;
    logic            pending_q;
    logic            tick;
    logic            stable;
    logic            want;

    assign tick   = (cnt_q == CntW'(SAMPLE_DIV - 1));
    assign stable = (s1_q == s2_q);
    // A tick can be taken in its own cycle; a second tick while one is outstanding merges.
    assign want   = tick | pending_q;
    assign accept = want & stable;
    assign sample = s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            cnt_q     <= tick ? '0 : cnt_q + CntW'(1);
            pending_q <= want & ~stable;
        end
    end

endmodule

// File: rtl/tilt_filter.sv
// Moving-average filter plus hysteresis FSM turning the accelerometer lateral axis into a
// debounced left/right tilt decision with a saturated intensity.
module tilt_filter
    import tilt_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = DefSampleDiv,
    parameter int unsigned AVG_LOG2   = DefAvgLog2,
    parameter int unsigned ENTER_TH   = DefEnterTh,
    parameter int unsigned EXIT_TH    = DefExitTh
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] acl_data,
    output logic        tilt_left,
    output logic        tilt_right,
    output logic [3:0]  tilt_intensity,
    output logic [4:0]  filt_avg,
    output logic        upd_strobe
);

    localparam int unsigned Depth = 1 << AVG_LOG2;
    localparam int unsigned SumW  = 5 + AVG_LOG2;
    localparam logic signed [5:0] EnterP = 6'(ENTER_TH);
    localparam logic signed [5:0] ExitP  = 6'(EXIT_TH);

    logic                   accept;
    logic [4:0]             sample;
    logic [4:0]             win_q [Depth];
    logic signed [SumW-1:0] sum_q;
    logic signed [SumW-1:0] samp_x;
    logic signed [SumW-1:0] old_x;
    logic                   upd_q;
    tilt_state_e            state_q;
    tilt_state_e            state_d;
    logic signed [4:0]      avg;
    logic signed [5:0]      avg_x;
    logic [3:0]             inten_d;
    logic                   acl_unused;

    assign acl_unused = ^{acl_data[14:10], acl_data[4:0]};

    acl_sample_sync #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .raw   (acl_data[9:5]),
        .accept(accept),
        .sample(sample)
    );

    assign samp_x = {{AVG_LOG2{sample[4]}}, sample};
    assign old_x  = {{AVG_LOG2{win_q[Depth-1][4]}}, win_q[Depth-1]};
    // The top five bits of the sum are exactly sum >>> AVG_LOG2 (floor toward -inf).
    assign avg    = sum_q[SumW-1 -: 5];
    assign avg_x  = {avg[4], avg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                win_q[i] <= '0;
            end
            sum_q <= '0;
        end else if (accept) begin
            win_q[0] <= sample;
            for (int i = int'(Depth) - 1; i > 0; i--) begin
                win_q[i] <= win_q[i-1];
            end
            sum_q <= sum_q + samp_x - old_x;
        end
    end

    // Crossovers are tested before the return to centre so a sign flip never passes through it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCenter: begin
                if (avg_x >= EnterP) state_d = StLeft;
                else if (avg_x <= -EnterP) state_d = StRight;
            end
            StLeft: begin
                if (avg_x <= -EnterP) state_d = StRight;
                else if (avg_x < ExitP) state_d = StCenter;
            end
            StRight: begin
                if (avg_x >= EnterP) state_d = StLeft;
                else if (avg_x > -ExitP) state_d = StCenter;
            end
            default: state_d = StCenter;
        endcase
        inten_d = (state_d == StCenter) ? 4'd0 : sat_abs5(avg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_q          <= 1'b0;
            upd_strobe     <= 1'b0;
            state_q        <= StCenter;
            tilt_left      <= 1'b0;
            tilt_right     <= 1'b0;
            tilt_intensity <= '0;
            filt_avg       <= '0;
        end else begin
            upd_q      <= accept;
            upd_strobe <= upd_q;
            if (upd_q) begin
                state_q        <= state_d;
                tilt_left      <= (state_d == StLeft);
                tilt_right     <= (state_d == StRight);
                tilt_intensity <= inten_d;
                filt_avg       <= avg;
            end
        end
    end

endmodule

// File: tb/tb_tilt_filter.sv
// Randomised self-checking bench for tilt_filter against a queue-based average/hysteresis model.
module tb_tilt_filter;

    localparam int unsigned SD    = 8;
    localparam int unsigned AL    = 2;
    localparam int          ENTER = 3;
    localparam int          EXIT  = 1;
    localparam int          N     = 1 << AL;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] acl_data;
    logic        tilt_left;
    logic        tilt_right;
    logic [3:0]  tilt_intensity;
    logic [4:0]  filt_avg;
    logic        upd_strobe;

    int ecnt;
    int n_tests = 0;
    int n_fail  = 0;

    int win[$];
    int m_state;
    int m_avg;
    int m_int;

    tilt_filter #(
        .SAMPLE_DIV(SD),
        .AVG_LOG2  (AL),
        .ENTER_TH  (ENTER),
        .EXIT_TH   (EXIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .acl_data      (acl_data),
        .tilt_left     (tilt_left),
        .tilt_right    (tilt_right),
        .tilt_intensity(tilt_intensity),
        .filt_avg      (filt_avg),
        .upd_strobe    (upd_strobe)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        for (int i = 0; i < N; i++) win.push_back(0);
        m_state = 0;
        m_avg   = 0;
        m_int   = 0;
    endtask

    // 0 = centre, 1 = left, 2 = right
    task automatic model_accept(input logic [4:0] v);
        int s;
        s = 0;
        win.push_back(int'($signed(v)));
        void'(win.pop_front());
        foreach (win[i]) s += win[i];
        m_avg = (s >= 0) ? s / N : -((-s + N - 1) / N);
        case (m_state)
            0: if (m_avg >= ENTER) m_state = 1; else if (m_avg <= -ENTER) m_state = 2;
            1: if (m_avg <= -ENTER) m_state = 2; else if (m_avg < EXIT) m_state = 0;
            default: if (m_avg >= ENTER) m_state = 1; else if (m_avg > -EXIT) m_state = 0;
        endcase
        if (m_state == 0) m_int = 0;
        else if (m_avg < -15) m_int = 15;
        else m_int = (m_avg < 0) ? -m_avg : m_avg;
    endtask

    task automatic drive(input logic [4:0] v);
        logic [14:0] w;
        w = 15'($urandom);
        w[9:5] = v;
        acl_data = w;
    endtask

    task automatic check_update();
        check("strobe", int'(upd_strobe), 1);
        check("left", int'(tilt_left), int'(m_state == 1));
        check("right", int'(tilt_right), int'(m_state == 2));
        check("intensity", int'(tilt_intensity), m_int);
        check("avg", int'($signed(filt_avg)), m_avg);
    endtask

    task automatic check_zero(input string p);
        check({p, "_left"}, int'(tilt_left), 0);
        check({p, "_right"}, int'(tilt_right), 0);
        check({p, "_intensity"}, int'(tilt_intensity), 0);
        check({p, "_avg"}, int'(filt_avg), 0);
        check({p, "_strobe"}, int'(upd_strobe), 0);
    endtask

    // Waits for the next sample update, checking the strobe stays low until then.
    task automatic run_to_update(input logic [4:0] v);
        int  guard;
        bit  done;
        guard = 0;
        done  = 1'b0;
        model_accept(v);
        while (!done) begin
            @(negedge clk);
            guard++;
            if (ecnt > int'(SD) && (ecnt % int'(SD)) == 1) begin
                check_update();
                done = 1'b1;
            end else begin
                check("quiet", int'(upd_strobe), 0);
                if (guard > 2 * int'(SD) + 2) begin
                    check("update_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic sample(input logic [4:0] v);
        drive(v);
        run_to_update(v);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] v;
        logic [4:0] a;
        logic [4:0] b;
        int         k;
        int         guard;

        rst = 1'b1;
        acl_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        repeat (4) sample(5'd8);          // left entry
        repeat (4) sample(5'd2);          // hysteresis hold
        repeat (4) sample(5'd0);          // return to centre
        repeat (4) sample(5'd8);
        repeat (4) sample(5'b10000);      // crossover and saturation

        repeat (40) begin
            v = 5'($urandom);
            k = $urandom_range(1, 4);
            repeat (k) sample(v);
        end

        // Unstable input across two ticks, then freeze.
        v = 5'd6;
        sample(v);
        a = v ^ 5'h05;
        b = v ^ 5'h0a;
        for (int i = 0; i < 2 * int'(SD); i++) begin
            drive((i % 2) != 0 ? b : a);
            @(negedge clk);
            check("unstable_quiet", int'(upd_strobe), 0);
        end
        drive(v);
        model_accept(v);
        repeat (3) begin
            @(negedge clk);
            check("freeze_quiet", int'(upd_strobe), 0);
        end
        @(negedge clk);
        check_update();
        @(negedge clk);
        check("strobe_once", int'(upd_strobe), 0);
        run_to_update(v);

        // Reset between accept and update.
        repeat (4) sample(5'd8);
        drive(5'd12);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(ecnt > int'(SD) && (ecnt % int'(SD)) == 0) && guard < 4 * int'(SD));
        check("mid_align", int'(ecnt % int'(SD)), 0);
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        check_zero("mid_rst_hold");
        rst = 1'b0;
        model_reset();
        repeat (4) sample(5'b11100);
        repeat (3) sample(5'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tilt_filter.md
# tilt_filter

Conditions the raw accelerometer word from the SPI master into a stable, debounced tilt decision for the game logic. The block sits between `spi_master` (4 MHz domain) and `vga_controller` / the LED feedback logic. It synchronises the lateral-axis field into the system clock domain, samples it at a fixed rate, and low-pass filters it with a moving average. It then applies a hysteresis state machine to produce `tilt_left`, `tilt_right` and a saturated 4-bit `tilt_intensity`.

## Interface
- `SAMPLE_DIV`, 100000 — system clocks between sample ticks; must be ≥ 4.
- `AVG_LOG2`, 2 — moving-average window is 2^AVG_LOG2 samples; range 1..4.
- `ENTER_TH`, 3 — average magnitude that enters LEFT or RIGHT; range 1..15.
- `EXIT_TH`, 1 — average magnitude below which LEFT or RIGHT returns to CENTER; must be < ENTER_TH.
- `clk  in  1` — system clock (ClkPort).
- `rst  in  1` — reset, asynchronous, active-high.
- `acl_data  in  15` — raw SPI word, asynchronous to `clk`. Bits [9:5] are the lateral axis as a 5-bit two's-complement value; negative means tilt right. All other bits are ignored.
- `tilt_left  out  1` — registered; high in LEFT.
- `tilt_right  out  1` — registered; high in RIGHT.
- `tilt_intensity  out  4` — registered; saturated |average|, forced to 0 in CENTER.
- `filt_avg  out  5` — registered signed moving average, for debug and SSD display.
- `upd_strobe  out  1` — one-cycle pulse when the outputs above have just been updated.

## Operation
- **Synchroniser:** two flops on `acl_data[9:5]`, giving `s1` then `s2`. The value is *stable* when `s1 == s2`.
- **Tick counter:** counts 0..SAMPLE_DIV-1 and wraps. It asserts `tick` for one cycle on the wrap.
- **Pending flag:**
  - `tick` sets `pending`.
  - A cycle with `pending && stable` accepts `s2`, then clears `pending`.
  - A tick that arrives while `pending` is already set is absorbed; at most one sample is outstanding.
  - While the value is unstable, acceptance retries every cycle.
- **Window on accept:**
  - The window shift register shifts in `s2` and drops the oldest entry.
  - `sum <= sum + s2 - oldest`. `sum` is signed, 5+AVG_LOG2 bits, and cannot overflow.
  - `avg = sum >>> AVG_LOG2` (arithmetic shift, floor toward −∞), giving a range of −16..15.
- **FSM** (states CENTER, LEFT, RIGHT) is evaluated only on the cycle after an accept, using the new `avg`:
  - CENTER → LEFT if avg ≥ ENTER_TH.
  - CENTER → RIGHT if avg ≤ −ENTER_TH.
  - LEFT → RIGHT if avg ≤ −ENTER_TH. This direct crossover has priority over the return to CENTER.
  - LEFT → CENTER if avg < EXIT_TH.
  - RIGHT → LEFT if avg ≥ ENTER_TH (direct crossover, same priority rule).
  - RIGHT → CENTER if avg > −EXIT_TH.
  - Otherwise the state holds.
- **Intensity:** |avg|, with −16 saturating to 15. It is 0 whenever the next state is CENTER.
- **Reset** (asserted at any time, including while `pending` or mid-pipeline):
  - `tilt_left`, `tilt_right`, `upd_strobe` = 0; `tilt_intensity` = 0; `filt_avg` = 0.
  - State = CENTER; window and sum = 0.
  - Tick counter = 0; `pending` = 0; synchroniser flops = 0.
  - After release, the first tick occurs SAMPLE_DIV cycles later.

## Timing
- An `acl_data` change reaches `s2` after 2 clock edges.
- Pipeline per accepted sample:
  - Accept at edge A updates the window and sum.
  - Edge A+1 updates the state, `tilt_*`, `filt_avg`, and asserts `upd_strobe`.
  - Edge A+2 deasserts `upd_strobe`.
- Latency from a tick with stable input to updated outputs is 2 cycles.
- The filter settles after 2^AVG_LOG2 accepted samples.
- Outputs change only at A+1 edges; they hold between updates.

## Structure
- Package `tilt_pkg` holds:
  - the state enum (CENTER=0, LEFT=1, RIGHT=2);
  - the default threshold and window constants;
  - a `sat_abs5` function returning a 4-bit magnitude.
- One sub-module, `acl_sample_sync`, contains the synchroniser, the stability compare, the tick counter and the pending logic. It outputs `accept` and `sample[4:0]`.
- `tilt_filter` contains the window, sum, FSM and output registers.

## Test plan
- **Reset defaults:** assert `rst` → all outputs 0 and state CENTER. Release and hold `acl_data[9:5]`=0 → no `upd_strobe` during the first SAMPLE_DIV−1 cycles.
- **Left entry:** hold +8 (AVG_LOG2=2, ENTER_TH=3) → avg steps 2, 4, 6, 8 over 4 accepts. LEFT is asserted on the 2nd update with intensity 4; after the 4th, intensity is 8 and `upd_strobe` pulses once per accept.
- **Hysteresis:** from steady +8, switch input to +2 → avg falls to 2. LEFT holds (2 ≥ EXIT_TH) and intensity is 2. Switch input to 0 → CENTER once avg < 1, intensity 0.
- **Saturation and crossover:** from steady LEFT, drive −16 (5'b10000) → RIGHT once avg ≤ −3, with no intermediate CENTER update. The final avg is −16 with intensity 15.
- **Unstable input:** toggle `acl_data[9:5]` every clock across a tick → no accept while toggling. Freeze the value → exactly one accept and one `upd_strobe`, even if 2 ticks elapsed.
- **Reset mid-operation:** assert `rst` on the cycle between accept and update → no `upd_strobe`, outputs 0. After release, the first update reflects only post-reset samples.
